// File: rtl/wb_stage_pipe.sv
//------------------------------------------------------------------------------
// Module      : wb_stage_pipe
// Description : Single-entry write-back stage: result select, load alignment
//               and sign extension, register-file write strobe, retire counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_stage_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic                                stall_i,
  input  logic [REG_ADDR_W-1:0]               rd_add_i,
  input  logic                                regwrite_i,
  input  logic [1:0]                          sel_to_reg_i,
  input  logic [DATA_WIDTH-1:0]               pc_i,
  input  logic [DATA_WIDTH-1:0]               imm_i,
  input  logic [DATA_WIDTH-1:0]               alu_result_i,
  input  logic [1:0]                          load_size_i,
  input  logic                                load_unsigned_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     byte_off_i,
  input  logic [DATA_WIDTH-1:0]               dmem_data_i,
  output logic [REG_ADDR_W-1:0]               rd_add_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                regwrite_o,
  output logic                                valid_o,
  output logic [31:0]                         retire_count_o
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);

  localparam logic [1:0] C_SEL_LINK = 2'b00;
  localparam logic [1:0] C_SEL_ALU  = 2'b01;
  localparam logic [1:0] C_SEL_LOAD = 2'b10;
  localparam logic [1:0] C_SEL_IMM  = 2'b11;

  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_regwrite;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [OFF_W-1:0]      r_off;
  logic [31:0]           r_retire_cnt;

  // Entry register: reload only when the stage is not held downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_sel      <= '0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_alu      <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
    end else if (!stall_i) begin
      r_valid <= in_valid_i;
      if (in_valid_i) begin
        r_rd       <= rd_add_i;
        r_regwrite <= regwrite_i;
        r_sel      <= sel_to_reg_i;
        r_pc       <= pc_i;
        r_imm      <= imm_i;
        r_alu      <= alu_result_i;
        r_size     <= load_size_i;
        r_unsigned <= load_unsigned_i;
        r_off      <= byte_off_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !stall_i) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  // Load alignment: shift the addressed lane down to bit 0.
  logic [OFF_W+2:0]      w_byte_sh;
  logic [OFF_W+2:0]      w_half_sh;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_sx;
  logic [DATA_WIDTH-1:0] w_load_byte;
  logic [DATA_WIDTH-1:0] w_load_half;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_byte_sh = {r_off, 3'b000};
  assign w_half_sh = {r_off[OFF_W-1:1], 4'b0000};
  assign w_byte    = 8'(dmem_data_i >> w_byte_sh);
  assign w_half    = 16'(dmem_data_i >> w_half_sh);
  assign w_sx      = ~r_unsigned;

  assign w_load_byte = {{(DATA_WIDTH-8){w_sx & w_byte[7]}}, w_byte};
  assign w_load_half = {{(DATA_WIDTH-16){w_sx & w_half[15]}}, w_half};

  generate
    if (DATA_WIDTH > 32) begin : g_word_lane
      logic [OFF_W+2:0] w_word_sh;
      logic [31:0]      w_word;
      assign w_word_sh   = {r_off[OFF_W-1:2], 5'b00000};
      assign w_word      = 32'(dmem_data_i >> w_word_sh);
      assign w_load_word = {{(DATA_WIDTH-32){w_sx & w_word[31]}}, w_word};
    end else begin : g_word_full
      assign w_load_word = dmem_data_i;
    end
  endgenerate

  always_comb begin
    w_load = dmem_data_i;
    case (r_size)
      C_SZ_BYTE: w_load = w_load_byte;
      C_SZ_HALF: w_load = w_load_half;
      C_SZ_WORD: w_load = w_load_word;
      default:   w_load = dmem_data_i;
    endcase
  end

  always_comb begin
    data_o = r_pc + DATA_WIDTH'(4);
    case (r_sel)
      C_SEL_LINK: data_o = r_pc + DATA_WIDTH'(4);
      C_SEL_ALU:  data_o = r_alu;
      C_SEL_LOAD: data_o = w_load;
      C_SEL_IMM:  data_o = r_imm;
      default:    data_o = r_pc + DATA_WIDTH'(4);
    endcase
  end

  assign in_ready_o     = ~stall_i;
  assign valid_o        = r_valid;
  assign rd_add_o       = r_rd;
  assign regwrite_o     = r_valid & r_regwrite & ~stall_i & (r_rd != '0);
  assign retire_count_o = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_stage_pipe
// Description : Scoreboard bench for wb_stage_pipe (DATA_WIDTH = 32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          stall_i;
  logic [AW-1:0] rd_add_i;
  logic          regwrite_i;
  logic [1:0]    sel_to_reg_i;
  logic [DW-1:0] pc_i;
  logic [DW-1:0] imm_i;
  logic [DW-1:0] alu_result_i;
  logic [1:0]    load_size_i;
  logic          load_unsigned_i;
  logic [1:0]    byte_off_i;
  logic [DW-1:0] dmem_data_i;
  logic [AW-1:0] rd_add_o;
  logic [DW-1:0] data_o;
  logic          regwrite_o;
  logic          valid_o;
  logic [31:0]   retire_count_o;

  wb_stage_pipe #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .stall_i         (stall_i),
    .rd_add_i        (rd_add_i),
    .regwrite_i      (regwrite_i),
    .sel_to_reg_i    (sel_to_reg_i),
    .pc_i            (pc_i),
    .imm_i           (imm_i),
    .alu_result_i    (alu_result_i),
    .load_size_i     (load_size_i),
    .load_unsigned_i (load_unsigned_i),
    .byte_off_i      (byte_off_i),
    .dmem_data_i     (dmem_data_i),
    .rd_add_o        (rd_add_o),
    .data_o          (data_o),
    .regwrite_o      (regwrite_o),
    .valid_o         (valid_o),
    .retire_count_o  (retire_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  n_writes = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference for the write-back value.
  function automatic logic [31:0] model(input logic [1:0] sel, input logic [31:0] pc,
                                        input logic [31:0] imm, input logic [31:0] alu,
                                        input logic [1:0] size, input logic uns,
                                        input logic [1:0] off, input logic [31:0] dmem);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    b = dmem[off*8 +: 8];
    h = off[1] ? dmem[31:16] : dmem[15:0];
    case (sel)
      2'b00:   r = pc + 32'd4;
      2'b01:   r = alu;
      2'b11:   r = imm;
      default: begin
        case (size)
          2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
          2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
          default: r = dmem;
        endcase
      end
    endcase
    return r;
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    #2;
    if (regwrite_o === 1'b1) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_wr", {63'd0, regwrite_o}, 64'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check_eq("sb_rd", {59'd0, rd_add_o}, {59'd0, e.rd});
        check_eq("sb_data", {32'd0, data_o}, {32'd0, e.data});
      end
    end
  end

  // Drive one instruction for a cycle, then present its DMEM data in the WB cycle.
  // Returns at the negedge starting the WB cycle.
  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                       input logic [1:0] size, input logic uns, input logic [1:0] off,
                       input logic [31:0] dmem, input bit push);
    @(negedge clk);
    in_valid_i      = 1'b1;
    stall_i         = 1'b0;
    rd_add_i        = rd;
    regwrite_i      = rw;
    sel_to_reg_i    = sel;
    pc_i            = pc;
    imm_i           = imm;
    alu_result_i    = alu;
    load_size_i     = size;
    load_unsigned_i = uns;
    byte_off_i      = off;
    dmem_data_i     = $urandom;
    if (push && rw && rd != 5'd0)
      sb_q.push_back('{rd: rd, data: model(sel, pc, imm, alu, size, uns, off, dmem)});
    @(negedge clk);
    in_valid_i   = 1'b0;
    dmem_data_i  = dmem;
    rd_add_i     = 5'($urandom);
    alu_result_i = $urandom;
    pc_i         = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cnt0;
    int          wr0;
    rst_n = 1'b0; in_valid_i = 1'b1; stall_i = 1'b1;
    rd_add_i = 5'd3; regwrite_i = 1'b1; sel_to_reg_i = 2'b01;
    pc_i = 32'h55; imm_i = 32'h66; alu_result_i = 32'h77;
    load_size_i = 2'b00; load_unsigned_i = 1'b0; byte_off_i = 2'd0; dmem_data_i = 32'h0;

    // Reset with stall/valid asserted: both are ignored.
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("rst_regwrite", {63'd0, regwrite_o}, 64'd0);
    check_eq("rst_rd", {59'd0, rd_add_o}, 64'd0);
    check_eq("rst_data", {32'd0, data_o}, 64'd4);
    check_eq("rst_retire", {32'd0, retire_count_o}, 64'd0);
    check_eq("rst_ready_stall", {63'd0, in_ready_o}, 64'd0);
    stall_i = 1'b0;
    #1;
    check_eq("rst_ready_run", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1; in_valid_i = 1'b0;

    // ALU write
    issue(5'd5, 1'b1, 2'b01, 32'h0, 32'h0, 32'h1234, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1);
    #2;
    check_eq("alu_regwrite", {63'd0, regwrite_o}, 64'd1);
    check_eq("alu_rd", {59'd0, rd_add_o}, 64'd5);
    check_eq("alu_data", {32'd0, data_o}, 64'h1234);
    check_eq("alu_retire_before", {32'd0, retire_count_o}, 64'd0);
    @(negedge clk); #2;
    check_eq("alu_retire_after", {32'd0, retire_count_o}, 64'd1);

    // Byte loads, signed then unsigned
    issue(5'd6, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2, 32'h0080FF00, 1'b1);
    #2; check_eq("ld_byte_signed", {32'd0, data_o}, 64'hFFFFFF80);
    issue(5'd6, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1, 2'd2, 32'h0080FF00, 1'b1);
    #2; check_eq("ld_byte_unsigned", {32'd0, data_o}, 64'h00000080);

    // Half load, off[0] ignored
    issue(5'd8, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 2'd3, 32'h80010000, 1'b1);
    #2; check_eq("ld_half_signed", {32'd0, data_o}, 64'hFFFF8001);

    // JAL link, then same to x0
    issue(5'd1, 1'b1, 2'b00, 32'h100, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1);
    #2;
    check_eq("jal_data", {32'd0, data_o}, 64'h104);
    check_eq("jal_regwrite", {63'd0, regwrite_o}, 64'd1);
    issue(5'd0, 1'b1, 2'b00, 32'h100, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1);
    #2;
    cnt0 = retire_count_o;
    check_eq("x0_regwrite", {63'd0, regwrite_o}, 64'd0);
    check_eq("x0_data", {32'd0, data_o}, 64'h104);
    @(negedge clk); #2;
    check_eq("x0_retire", {32'd0, retire_count_o}, {32'd0, cnt0 + 32'd1});

    // Stall for three cycles while the upstream keeps changing
    issue(5'd7, 1'b1, 2'b01, 32'h0, 32'h0, 32'h77, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1);
    stall_i = 1'b1; in_valid_i = 1'b1;
    cnt0 = retire_count_o;
    wr0  = n_writes;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_eq("stall_regwrite", {63'd0, regwrite_o}, 64'd0);
      check_eq("stall_valid", {63'd0, valid_o}, 64'd1);
      check_eq("stall_ready", {63'd0, in_ready_o}, 64'd0);
      check_eq("stall_rd", {59'd0, rd_add_o}, 64'd7);
      check_eq("stall_data", {32'd0, data_o}, 64'h77);
      check_eq("stall_retire", {32'd0, retire_count_o}, {32'd0, cnt0});
      @(negedge clk);
      rd_add_i = 5'($urandom); alu_result_i = $urandom; sel_to_reg_i = 2'($urandom);
    end
    stall_i = 1'b0; in_valid_i = 1'b0;
    #2; check_eq("release_regwrite", {63'd0, regwrite_o}, 64'd1);
    repeat (2) @(negedge clk);
    #3;
    check_eq("release_one_write", n_writes, wr0 + 1);
    check_eq("release_retire", {32'd0, retire_count_o}, {32'd0, cnt0 + 32'd1});

    // Reset while a stalled entry is held
    issue(5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 32'h99, 2'b00, 1'b0, 2'd0, 32'h0, 1'b0);
    stall_i = 1'b1; in_valid_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #2;
    check_eq("rststall_valid", {63'd0, valid_o}, 64'd0);
    check_eq("rststall_retire", {32'd0, retire_count_o}, 64'd0);
    check_eq("rststall_regwrite", {63'd0, regwrite_o}, 64'd0);
    check_eq("rststall_data", {32'd0, data_o}, 64'd4);
    @(negedge clk);
    rst_n = 1'b1; stall_i = 1'b0; in_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Counter wrap
    dut.r_retire_cnt <= 32'hFFFF_FFFF;
    #2; check_eq("wrap_preset", {32'd0, retire_count_o}, 64'hFFFF_FFFF);
    issue(5'd0, 1'b0, 2'b01, 32'h0, 32'h0, 32'h1, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1);
    @(negedge clk); #2;
    check_eq("wrap_zero", {32'd0, retire_count_o}, 64'd0);

    // Random mix through the scoreboard
    for (int i = 0; i < 12; i++) begin
      issue(5'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
            2'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'b1);
    end
    repeat (3) @(negedge clk);
    #3;
    check_eq("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 The block SHALL have derived localparam OFF_W = clog2(DATA_WIDTH/8), the byte-offset width.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid_i  in  1  MEM stage presents an instruction.
- in_ready_o  out  1  stage accepts input this cycle.
- stall_i  in  1  downstream hold; freezes the stage.
- rd_add_i  in  REG_ADDR_W  destination register.
- regwrite_i  in  1  instruction writes the register file.
- sel_to_reg_i  in  2  result select.
- pc_i  in  DATA_WIDTH  instruction PC.
- imm_i  in  DATA_WIDTH  immediate (LUI-type result).
- alu_result_i  in  DATA_WIDTH  ALU result.
- load_size_i  in  2  00 byte, 01 half, 10 word, 11 full width.
- load_unsigned_i  in  1  zero-extend load when 1.
- byte_off_i  in  OFF_W  load byte offset within the DMEM word.
- dmem_data_i  in  DATA_WIDTH  DMEM read data, valid in the WB cycle (unregistered).
- rd_add_o  out  REG_ADDR_W  write address.
- data_o  out  DATA_WIDTH  write data.
- regwrite_o  out  1  register-file write strobe.
- valid_o  out  1  stage holds a valid instruction.
- retire_count_o  out  32  retired-instruction counter.

Function
REQ-006 The stage SHALL hold a single entry: valid_q plus registered copies of every *_i field except dmem_data_i.
REQ-007 in_ready_o SHALL equal !stall_i.
REQ-008 When stall_i=0 at a rising edge, the stage SHALL load valid_q <= in_valid_i and SHALL load all fields when in_valid_i=1; when in_valid_i=0, fields SHALL be don't-care.
REQ-009 When stall_i=1, the stage SHALL hold all registers unchanged.
REQ-010 valid_o SHALL equal valid_q.
REQ-011 regwrite_o SHALL equal valid_q & regwrite_q & !stall_i & (rd_q != 0).
REQ-012 A held entry SHALL write exactly once: in the first cycle in which stall_i=0.
REQ-013 rd_add_o SHALL equal rd_q combinationally.
REQ-014 data_o SHALL be a purely combinational mux, with no latch inferred:
- sel 00: pc_q + 4, truncated to DATA_WIDTH.
- sel 01: alu_q.
- sel 10: aligned load value (REQ-015 to REQ-017).
- sel 11: imm_q.
REQ-015 Aligned load byte SHALL be dmem_data_i[8*off +: 8].
REQ-016 Aligned load half SHALL be dmem_data_i[16*(off>>1) +: 16], with off[0] ignored.
REQ-017 Aligned load word SHALL be dmem_data_i[32*(off>>2) +: 32]; when DATA_WIDTH=32 this is the full word. Full width SHALL be dmem_data_i unchanged.
REQ-018 Byte, half and word (when narrower than DATA_WIDTH) loads SHALL be sign-extended from their MSB when unsigned_q=0 and zero-extended when unsigned_q=1. Full-width loads SHALL ignore unsigned_q.
REQ-019 retire_count_o SHALL increment by 1 on each edge where valid_q & !stall_i, regardless of regwrite_q.
REQ-020 retire_count_o SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 While valid_q=0, data_o SHALL still follow the mux; consumers SHALL qualify it with regwrite_o.

Reset
REQ-022 When rst_n=0 at a rising edge, the following SHALL be cleared to 0: valid_q, all field registers, and retire_count_o.
REQ-023 While reset is applied, stall_i and in_valid_i SHALL be ignored.
REQ-024 Once reset has taken effect: regwrite_o=0, valid_o=0, rd_add_o=0, data_o=4 (sel 00, pc 0), in_ready_o=!stall_i.
REQ-025 Reset asserted mid-operation SHALL discard the pending entry with no write, including a stalled entry.

Verification
REQ-026 Bench: ALU write. in: valid, rd=5, regwrite, sel 01, alu=0x1234, stall 0 -> next cycle: regwrite_o=1, rd_add_o=5, data_o=0x1234, retire_count_o becomes 1 one edge later.
REQ-027 Bench: signed byte load. sel 10, size 00, unsigned 0, off=2, dmem=0x0080FF00 -> data_o=0xFFFFFF80; with unsigned 1 -> 0x00000080.
REQ-028 Bench: half load. size 01, off=3, dmem=0x8001_0000, signed -> data_o=0xFFFF8001 (off[0] ignored).
REQ-029 Bench: JAL link and x0 writes.
- sel 00, pc=0x100, rd=1 -> data_o=0x104, regwrite_o=1.
- Same instruction with rd=0 -> regwrite_o=0, retire count still increments.
REQ-030 Bench: stall. Capture entry rd=7, then stall_i=1 for 3 cycles with new inputs changing.
- During stall: regwrite_o=0, valid_o=1, in_ready_o=0, fields unchanged.
- Stall release: one write to rd 7 with the original data.
- retire_count_o increments exactly once.
REQ-031 Bench: reset during stall, and counter wrap.
- Assert rst_n=0 while a stalled entry is held -> no write, valid_o=0, retire_count_o=0.
- Counter wrap: force count 0xFFFFFFFF, retire one instruction -> 0.
